// File: rtl/mem_wb_lsu.sv
// MEM-stage load/store unit with MEM/WB pipeline register and bus-timeout handling.
// Optional MISALIGN_TRAP_EN: trap misaligned half/word accesses instead of aligning them down.
module mem_wb_lsu #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ex_mem_valid,
    input  logic [31:0] ex_mem_alu_result,
    input  logic [31:0] ex_mem_store_data,
    input  logic        ex_mem_MemRead,
    input  logic        ex_mem_MemWrite,
    input  logic [2:0]  ex_mem_funct3,
    input  logic [4:0]  ex_mem_Rd,
    input  logic        ex_mem_RegWrite,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        mem_stall,
    output logic        MEM_WB_valid,
    output logic [31:0] mem_out,
    output logic [31:0] MEM_WB_Rd_data,
    output logic        MEM_WB_RWSet,
    output logic [4:0]  MEM_WB_Rd,
    output logic        MEM_WB_RegWrite,
`ifdef MISALIGN_TRAP_EN
    output logic        misalign_exc,
`endif
    output logic        bus_err
);
    typedef enum logic {S_IDLE, S_REQ} state_t;

    state_t      r_state, w_next;
    logic [31:0] r_cnt;
    logic        r_we, r_load, r_rw, r_bus_err;
    logic [31:0] r_addr, r_wdata;
    logic [3:0]  r_be;
    logic [2:0]  r_f3;
    logic [1:0]  r_lo;
    logic [4:0]  r_rd;
    logic        r_wb_valid, r_wb_rwset, r_wb_rw;
    logic [31:0] r_mem_out, r_wb_data;
    logic [4:0]  r_wb_rd;

    logic        w_load, w_memop, w_accept, w_timeout;
    logic [1:0]  w_size, w_lo;
    logic [31:0] w_wdata, w_fmt;
    logic [3:0]  w_be;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_load  = ex_mem_MemRead;
    assign w_memop = ex_mem_valid & (ex_mem_MemRead | ex_mem_MemWrite);

    // Size code: 0 byte, 1 half, 2 word. Loads and stores decode funct3 differently.
    always_comb begin
        w_size = 2'd2;
        if (w_load) begin
            case (ex_mem_funct3)
                3'b000, 3'b100: w_size = 2'd0;
                3'b001, 3'b101: w_size = 2'd1;
                default:        w_size = 2'd2;
            endcase
        end else begin
            case (ex_mem_funct3)
                3'b000:  w_size = 2'd0;
                3'b001:  w_size = 2'd1;
                default: w_size = 2'd2;
            endcase
        end
    end

    always_comb begin
        w_lo    = ex_mem_alu_result[1:0];
        w_wdata = ex_mem_store_data;
        w_be    = 4'b1111;
        case (w_size)
            2'd0: begin
                w_wdata = {4{ex_mem_store_data[7:0]}};
                w_be    = 4'b0001 << ex_mem_alu_result[1:0];
            end
            2'd1: begin
                w_lo    = {ex_mem_alu_result[1], 1'b0};
                w_wdata = {2{ex_mem_store_data[15:0]}};
                w_be    = 4'b0011 << {ex_mem_alu_result[1], 1'b0};
            end
            default: w_lo = 2'b00;
        endcase
    end

`ifdef MISALIGN_TRAP_EN
    logic w_misal, r_misal;
    assign w_misal  = ((w_size == 2'd1) & ex_mem_alu_result[0]) |
                      ((w_size == 2'd2) & (ex_mem_alu_result[1:0] != 2'b00));
    assign w_accept = w_memop & ~w_misal;
    assign misalign_exc = r_misal;
`else
    assign w_accept = w_memop;
`endif

    // Ack in the timeout cycle takes priority, so timeout requires no ack.
    assign w_timeout = (TIMEOUT_CYCLES != 0) && (r_state == S_REQ) && !dmem_ack &&
                       (r_cnt == TIMEOUT_CYCLES - 1);

    always_comb begin
        w_next    = r_state;
        mem_stall = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next    = S_REQ;
                    mem_stall = 1'b1;
                end
            end
            S_REQ: begin
                mem_stall = ~dmem_ack & ~w_timeout;
                if (dmem_ack | w_timeout) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        case (r_lo)
            2'd0:    w_byte = dmem_rdata[7:0];
            2'd1:    w_byte = dmem_rdata[15:8];
            2'd2:    w_byte = dmem_rdata[23:16];
            default: w_byte = dmem_rdata[31:24];
        endcase
        w_half = r_lo[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (r_f3)
            3'b000:  w_fmt = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_fmt = {{16{w_half[15]}}, w_half};
            3'b100:  w_fmt = {24'd0, w_byte};
            3'b101:  w_fmt = {16'd0, w_half};
            default: w_fmt = dmem_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_we       <= 1'b0;
            r_load     <= 1'b0;
            r_rw       <= 1'b0;
            r_bus_err  <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_be       <= '0;
            r_f3       <= '0;
            r_lo       <= '0;
            r_rd       <= '0;
            r_wb_valid <= 1'b0;
            r_wb_rwset <= 1'b0;
            r_wb_rw    <= 1'b0;
            r_mem_out  <= '0;
            r_wb_data  <= '0;
            r_wb_rd    <= '0;
`ifdef MISALIGN_TRAP_EN
            r_misal    <= 1'b0;
`endif
        end else begin
            r_state    <= w_next;
            r_bus_err  <= w_timeout;
            r_wb_valid <= 1'b0;
            r_wb_rw    <= 1'b0;
`ifdef MISALIGN_TRAP_EN
            r_misal    <= (r_state == S_IDLE) & w_memop & w_misal;
`endif
            if (r_state == S_IDLE) begin
                if (w_accept) begin
                    r_we    <= ~ex_mem_MemRead & ex_mem_MemWrite;
                    r_load  <= w_load;
                    r_addr  <= {ex_mem_alu_result[31:2], 2'b00};
                    r_wdata <= w_wdata;
                    r_be    <= w_be;
                    r_f3    <= ex_mem_funct3;
                    r_lo    <= w_lo;
                    r_rd    <= ex_mem_Rd;
                    r_rw    <= ex_mem_RegWrite;
                    r_cnt   <= '0;
                end else if (ex_mem_valid & ~w_memop) begin
                    r_wb_valid <= 1'b1;
                    r_wb_data  <= ex_mem_alu_result;
                    r_wb_rwset <= 1'b1;
                    r_wb_rd    <= ex_mem_Rd;
                    r_wb_rw    <= ex_mem_RegWrite;
                end
            end else if (dmem_ack) begin
                r_wb_valid <= 1'b1;
                r_wb_rw    <= r_rw & r_load;
                r_wb_rwset <= ~r_load;
                r_wb_data  <= {r_addr[31:2], r_lo};
                r_wb_rd    <= r_rd;
                if (r_load) r_mem_out <= w_fmt;
            end else begin
                r_cnt <= r_cnt + 32'd1;
            end
        end
    end

    assign dmem_req        = (r_state == S_REQ);
    assign dmem_we         = r_we;
    assign dmem_addr       = r_addr;
    assign dmem_wdata      = r_wdata;
    assign dmem_be         = r_be;
    assign bus_err         = r_bus_err;
    assign MEM_WB_valid    = r_wb_valid;
    assign mem_out         = r_mem_out;
    assign MEM_WB_Rd_data  = r_wb_data;
    assign MEM_WB_RWSet    = r_wb_rwset;
    assign MEM_WB_Rd       = r_wb_rd;
    assign MEM_WB_RegWrite = r_wb_rw;
endmodule
